// File: rtl/bsg_reg_pkg.sv
// Shared definitions for the BSG register bank: CONTROL bit positions,
// per-channel register offsets and the packed CONTROL storage type.
package bsg_reg_pkg;

  localparam int TXEN_BIT    = 0;
  localparam int INTMSK_BIT  = 1;
  localparam int INTFLAG_BIT = 2;
  localparam int STATUS_BIT  = 3;

  localparam int OFF_CTRL = 0;
  localparam int OFF_DATA = 1;

  // Member order puts txen at bit 0 so the struct matches the CONTROL layout.
  typedef struct packed {
    logic status;
    logic intflag;
    logic intmsk;
    logic txen;
  } ctrl_t;

endpackage

// File: rtl/bsg_chan_regs.sv
// State for one BSG channel: CONTROL flops, DATA register, status sampling,
// falling-edge interrupt flag and the transmit start pulse.
module bsg_chan_regs
  import bsg_reg_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctrl_we,
  input  logic          data_we,
  input  logic [DW-1:0] wdata,
  input  logic          status_i,
  output logic [DW-1:0] ctrl_rdata,
  output logic [DW-1:0] data,
  output logic          tx_en,
  output logic          tx_start,
  output logic          irq_req
);

  ctrl_t         ctrl_q;
  logic [DW-1:0] data_q;
  logic          status_fall;

  // ctrl_q.status doubles as status_q; it resets to 0 so the first sample
  // after reset can never look like a falling edge.
  assign status_fall = ctrl_q.status & ~status_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      data_q   <= '0;
      tx_start <= 1'b0;
    end else begin
      ctrl_q.status <= status_i;
      if (ctrl_we) begin
        ctrl_q.txen   <= wdata[TXEN_BIT];
        ctrl_q.intmsk <= wdata[INTMSK_BIT];
      end
      // A new falling edge beats a simultaneous write-1-to-clear.
      if (status_fall)
        ctrl_q.intflag <= 1'b1;
      else if (ctrl_we && wdata[INTFLAG_BIT])
        ctrl_q.intflag <= 1'b0;
      if (data_we)
        data_q <= wdata;
      tx_start <= data_we & ctrl_q.txen & ~ctrl_q.status;
    end
  end

  always_comb begin
    ctrl_rdata              = '0;
    ctrl_rdata[TXEN_BIT]    = ctrl_q.txen;
    ctrl_rdata[INTMSK_BIT]  = ctrl_q.intmsk;
    ctrl_rdata[INTFLAG_BIT] = ctrl_q.intflag;
    ctrl_rdata[STATUS_BIT]  = ctrl_q.status;
  end

  assign data    = data_q;
  assign tx_en   = ctrl_q.txen;
  assign irq_req = ctrl_q.intflag & ctrl_q.intmsk;

endmodule

// File: rtl/bsg_reg_bank.sv
// Register bank for NCH BSG channels: address decode, registered read
// response with error pulse, and the combined interrupt output.
module bsg_reg_bank
  import bsg_reg_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int BASE = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bus_valid,
  input  logic            bus_write,
  input  logic [AW-1:0]   bus_addr,
  input  logic [DW-1:0]   bus_wdata,
  output logic [DW-1:0]   bus_rdata,
  output logic            bus_rvalid,
  output logic            bus_err,
  input  logic [NCH-1:0]  status_i,
  output logic [NCH-1:0]  tx_en_o,
  output logic [NCH-1:0]  tx_start_o,
  output logic [NCH*DW-1:0] data_o,
  output logic            irq_o
);

  // Bus handshake: an access is accepted in every cycle bus_valid=1 (no
  // back-pressure); reads answer with a one-cycle bus_rvalid pulse the next
  // cycle, unmapped accesses additionally pulse bus_err the next cycle.

  logic [AW-1:0] rel;
  logic          in_range;
  logic [AW-2:0] chan_sel;
  logic          is_data;
  logic          wr_ok;
  logic          rd_req;
  logic [DW-1:0] rd_mux;
  logic [NCH-1:0] irq_req;

  logic [DW-1:0] ctrl_rd  [NCH];
  logic [DW-1:0] data_arr [NCH];

  assign rel      = bus_addr - AW'(BASE);
  assign in_range = (bus_addr >= AW'(BASE)) && (rel < AW'(2 * NCH));
  assign chan_sel = rel[AW-1:1];
  assign is_data  = (rel[0] == 1'(OFF_DATA));
  assign wr_ok    = bus_valid & bus_write & in_range;
  assign rd_req   = bus_valid & ~bus_write;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    logic hit;
    assign hit = wr_ok && (chan_sel == (AW-1)'(k));

    bsg_chan_regs #(.DW(DW)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .ctrl_we    (hit & (rel[0] == 1'(OFF_CTRL))),
      .data_we    (hit & is_data),
      .wdata      (bus_wdata),
      .status_i   (status_i[k]),
      .ctrl_rdata (ctrl_rd[k]),
      .data       (data_arr[k]),
      .tx_en      (tx_en_o[k]),
      .tx_start   (tx_start_o[k]),
      .irq_req    (irq_req[k])
    );

    assign data_o[k*DW +: DW] = data_arr[k];
  end

  // Unmapped addresses fall through to zero read data.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NCH; k++) begin
      if (in_range && (chan_sel == (AW-1)'(k)))
        rd_mux = is_data ? data_arr[k] : ctrl_rd[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
      bus_err    <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      bus_rvalid <= rd_req;
      bus_err    <= bus_valid & ~in_range;
      if (rd_req)
        bus_rdata <= rd_mux;
      irq_o <= |irq_req;
    end
  end

endmodule

// File: tb/tb_bsg_reg_bank.sv
// Self-checking bench for bsg_reg_bank: read data flows through an expected
// queue, control outputs and pulse counters are checked directly.
module tb_bsg_reg_bank;

  localparam int NCH  = 2;
  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int BASE = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bus_valid = 1'b0;
  logic              bus_write = 1'b0;
  logic [AW-1:0]     bus_addr = '0;
  logic [DW-1:0]     bus_wdata = '0;
  logic [DW-1:0]     bus_rdata;
  logic              bus_rvalid;
  logic              bus_err;
  logic [NCH-1:0]    status_i = '0;
  logic [NCH-1:0]    tx_en_o;
  logic [NCH-1:0]    tx_start_o;
  logic [NCH*DW-1:0] data_o;
  logic              irq_o;

  bsg_reg_bank #(.NCH(NCH), .DW(DW), .AW(AW), .BASE(BASE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_valid  (bus_valid),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .bus_err    (bus_err),
    .status_i   (status_i),
    .tx_en_o    (tx_en_o),
    .tx_start_o (tx_start_o),
    .data_o     (data_o),
    .irq_o      (irq_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int start0_cnt = 0;
  int start1_cnt = 0;
  int err_cnt    = 0;
  int rvalid_cnt = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (tx_start_o[0]) start0_cnt++;
    if (tx_start_o[1]) start1_cnt++;
    if (bus_err) err_cnt++;
    if (bus_rvalid) begin
      rvalid_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", 32'(bus_rdata), 32'(e));
      end
    end
  end

  // driver tasks: all start and end 1ns after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus_valid = 1'b1;
    bus_write = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    tick(1);
    bus_valid = 1'b0;
    bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bus_valid = 1'b1;
    bus_write = 1'b0;
    bus_addr  = addr;
    exp_q.push_back(exp);
    tick(1);
    bus_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      tick(1);
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(2);
    chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_txen", 32'(tx_en_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // read after reset
    bus_rd(AW'(BASE), 8'h00);
    drain();
    chk("irq_idle", 32'(irq_o), 32'd0);

    // enable + start on channel 0
    start0_cnt = 0;
    bus_wr(AW'(BASE), 8'h03);
    bus_wr(AW'(BASE + 1), 8'hA5);
    chk("tx_start_next", 32'(tx_start_o[0]), 32'd1);
    tick(3);
    chk("tx_en0", 32'(tx_en_o[0]), 32'd1);
    chk("data0", 32'(data_o[7:0]), 32'hA5);
    chk("start0_pulses", 32'(start0_cnt), 32'd1);
    bus_rd(AW'(BASE), 8'h03);
    drain();

    // falling status on channel 0 sets flag, irq; W1C clears
    status_i[0] = 1'b1;
    tick(3);
    status_i[0] = 1'b0;
    tick(3);
    chk("irq_set", 32'(irq_o), 32'd1);
    bus_rd(AW'(BASE), 8'h07);
    drain();
    bus_wr(AW'(BASE), 8'h04);
    tick(2);
    chk("irq_clr", 32'(irq_o), 32'd0);
    bus_rd(AW'(BASE), 8'h00);
    drain();
    chk("tx_en0_off", 32'(tx_en_o[0]), 32'd0);
    chk("start0_none", 32'(start0_cnt), 32'd1);

    // set wins over simultaneous W1C on channel 1
    status_i[1] = 1'b1;
    tick(3);
    status_i[1] = 1'b0;
    bus_wr(AW'(BASE + 2), 8'h04);
    bus_rd(AW'(BASE + 2), 8'h04);
    drain();
    bus_wr(AW'(BASE + 2), 8'h04);
    bus_rd(AW'(BASE + 2), 8'h00);
    drain();

    // DATA write with TXEN=0: update only
    start1_cnt = 0;
    bus_wr(AW'(BASE + 3), 8'h3C);
    tick(2);
    chk("data1", 32'(data_o[15:8]), 32'h3C);
    chk("start1_none", 32'(start1_cnt), 32'd0);

    // unmapped accesses
    err_cnt = 0;
    bus_rd(AW'(BASE + 2 * NCH), 8'h00);
    drain();
    chk("err_rd_high", 32'(err_cnt), 32'd1);
    bus_rd(AW'(BASE - 1), 8'h00);
    drain();
    chk("err_rd_low", 32'(err_cnt), 32'd2);
    bus_wr(AW'(BASE + 2 * NCH), 8'hFF);
    tick(2);
    chk("err_wr", 32'(err_cnt), 32'd3);
    rvalid_cnt = 0;
    bus_rd(AW'(BASE), 8'h00);
    bus_rd(AW'(BASE + 1), 8'hA5);
    bus_rd(AW'(BASE + 2), 8'h00);
    bus_rd(AW'(BASE + 3), 8'h3C);
    drain();
    chk("b2b_count", 32'(rvalid_cnt), 32'd4);
    chk("err_mapped", 32'(err_cnt), 32'd3);

    // reset in the middle of back-to-back reads
    rvalid_cnt = 0;
    exp_q.push_back(8'h00);
    bus_valid = 1'b1;
    bus_write = 1'b0;
    bus_addr  = AW'(BASE);
    tick(1);
    bus_addr = AW'(BASE + 1);
    #6;
    rst_n     = 1'b0;
    bus_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rst_mid_rvalid", 32'(rvalid_cnt), 32'd1);
    chk("rst_mid_queue", 32'(exp_q.size()), 32'd0);
    chk("rst_mid_data", 32'(data_o), 32'd0);
    bus_rd(AW'(BASE + 1), 8'h00);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
